// File: rtl/lock_pkg.sv
// Shared definitions for both ends of the two-button combination lock:
// the default code width and the sender's state encoding.
package lock_pkg;

    localparam int LOCK_CODE_LEN = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } lock_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lock_gap_timer.sv
// Loadable down-counter that holds at zero; tc_o flags the terminal count.
module lock_gap_timer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Serialises a captured code word MSB first into one-cycle button presses
// separated by an idle gap, and records the lock's answer on the last press.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN   = LOCK_CODE_LEN,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    input  logic                unlock,
    output logic                button0,
    output logic                button1,
    output logic                busy,
    output logic                done,
    output logic                success
);

    localparam int IW = clog2_min1(CODE_LEN);
    localparam int GW = clog2_min1(GAP_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);
    // The counter is loaded at the press edge, so it spans GAP_CYCLES values ending at zero.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    lock_state_e         state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                success_q, success_d;
    logic                gap_load, gap_en, gap_tc;

    lock_gap_timer #(.W(GW)) u_gap_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .en_i       (gap_en),
        .tc_o       (gap_tc)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        success_d = success_q;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d    = code;
                    idx_d     = IDX_LAST;
                    success_d = 1'b0;
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                if (idx_q == '0) begin
                    success_d = unlock;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                    if (GAP_CYCLES != 0) begin
                        gap_load = 1'b1;
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                gap_en = 1'b1;
                if (gap_tc) begin
                    state_d = PRESS;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            idx_q     <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
            success_q <= success_d;
        end
    end

    // Buttons come only from flops, so start/unlock never reach them combinationally.
    assign button1 = (state_q == PRESS) &  code_q[idx_q];
    assign button0 = (state_q == PRESS) & ~code_q[idx_q];
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign success = success_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: two instances (gap 2 and gap 0) each looped back
// to a lock that opens on the press sequence 1,1,0,1,0.
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int L  = LOCK_CODE_LEN;
    localparam int EW = 34;
    localparam int NEVER = 1 << 30;
    localparam logic [L-1:0] SECRET = 5'b11010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [L-1:0] code = '0;
    bit           chk_en = 1'b0;
    int           tests = 0;
    int           fails = 0;
    int           pend[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int G = (g == 0) ? 2 : 0;

        logic          b0, b1, busy, done, success, unlock;
        logic [L-2:0]  hist;
        logic [EW-1:0] exp_q[$];
        int            m_cyc = 0;
        int            done_cyc = -1;
        int            busy_lo = NEVER;
        int            succ_from = NEVER;
        bit            succ_val = 1'b0;

        lock_code_sender #(.CODE_LEN(L), .GAP_CYCLES(G)) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .code    (code),
            .unlock  (unlock),
            .button0 (b0),
            .button1 (b1),
            .busy    (busy),
            .done    (done),
            .success (success)
        );

        // Lock: remembers earlier presses, opens combinationally on the matching final press.
        always @(posedge clk) begin
            if (rst) hist <= '0;
            else if (b0 | b1) hist <= {hist[L-3:0], b1};
        end
        assign unlock = (b0 ^ b1) && ({hist, b1} == SECRET);

        // Reference model: schedule of presses and done derived from the accepted start cycle.
        always @(posedge clk) begin
            logic [EW-1:0] ev;
            int k;
            int ecyc;
            if (rst) begin
                while (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    tests++;
                    if (int'(ev[EW-1:2]) <= m_cyc) begin
                        fails++;
                        $display("FAIL inst%0d missing_event: expected kind %0d at cycle %0d, not seen before reset", g, ev[1:0], ev[EW-1:2]);
                    end
                end
                done_cyc  = m_cyc;
                busy_lo   = NEVER;
                succ_from = NEVER;
                succ_val  = 1'b0;
            end else if (start && (m_cyc > done_cyc)) begin
                k         = m_cyc;
                busy_lo   = k + 1;
                done_cyc  = k + L + (L - 1) * G + 1;
                succ_from = done_cyc;
                succ_val  = (code == SECRET);
                for (int i = 0; i < L; i++) begin
                    ecyc = k + 1 + i * (G + 1);
                    exp_q.push_back({32'(ecyc), 1'b0, code[L-1-i]});
                end
                exp_q.push_back({32'(done_cyc), 2'd2});
            end
            pend[g] = exp_q.size();
            m_cyc++;
        end

        // Monitor: compares every cycle's outputs against the model's expectations.
        always @(negedge clk) begin
            logic [EW-1:0] ev;
            logic [1:0]    kind;
            bit            exp_busy, exp_s;
            if (chk_en) begin
                while (exp_q.size() > 0 && int'(exp_q[0][EW-1:2]) < m_cyc) begin
                    ev = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL inst%0d missing_event: expected kind %0d at cycle %0d, now cycle %0d", g, ev[1:0], ev[EW-1:2], m_cyc);
                end
                exp_busy = (m_cyc >= busy_lo) && (m_cyc <= done_cyc);
                exp_s    = (m_cyc >= succ_from) ? succ_val : 1'b0;
                tests++;
                if (busy !== exp_busy) begin
                    fails++;
                    $display("FAIL inst%0d busy cycle %0d: got %b want %b", g, m_cyc, busy, exp_busy);
                end
                tests++;
                if (success !== exp_s) begin
                    fails++;
                    $display("FAIL inst%0d success cycle %0d: got %b want %b", g, m_cyc, success, exp_s);
                end
                tests++;
                if ((b0 & b1) !== 1'b0) begin
                    fails++;
                    $display("FAIL inst%0d both_buttons cycle %0d: b0=%b b1=%b", g, m_cyc, b0, b1);
                end
                if (b0 === 1'b1 || b1 === 1'b1 || done === 1'b1) begin
                    kind = (done === 1'b1) ? 2'd2 : ((b1 === 1'b1) ? 2'd1 : 2'd0);
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL inst%0d unexpected_output cycle %0d: kind %0d, none expected", g, m_cyc, kind);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev !== {32'(m_cyc), kind}) begin
                            fails++;
                            $display("FAIL inst%0d event: got kind %0d at cycle %0d, want kind %0d at cycle %0d", g, kind, m_cyc, ev[1:0], ev[EW-1:2]);
                        end
                    end
                end
                pend[g] = exp_q.size();
            end
        end
    end

    task automatic send(input logic [L-1:0] c, input bit scramble);
        @(posedge clk); #1;
        start = 1'b1;
        code  = c;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (scramble) code = L'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(SECRET, 1'b0);
        send(5'b01011, 1'b0);
        send(5'b10101, 1'b0);
        send(SECRET, 1'b1);
        send(5'b00111, 1'b1);

        // Reset during the first gap of a send.
        @(posedge clk); #1;
        start = 1'b1;
        code  = SECRET;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Start held high, code constant then changing every cycle.
        start = 1'b1;
        code  = SECRET;
        repeat (45) @(posedge clk);
        #1;
        for (int i = 0; i < 50; i++) begin
            code = ($urandom_range(0, 2) == 0) ? SECRET : L'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) == 0);
            code  = ($urandom_range(0, 3) == 0) ? SECRET : L'($urandom);
            rst   = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;

        waited = 0;
        while ((pend[0] != 0 || pend[1] != 0) && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int g = 0; g < 2; g++) begin
            tests++;
            if (pend[g] != 0) begin
                fails++;
                $display("FAIL inst%0d drain: %0d events outstanding, want 0", g, pend[g]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Initiator side of the two-button combination-lock interface: serialises a stored code word into one-cycle button0/button1 press pulses and observes the lock's unlock response.
- Used as the keypad driver in system-level tests and as the auto-unlock engine in the lock subsystem.
- Presses are separated by a programmable idle gap. On the final press the block reports whether the lock opened.

Parameters:
- CODE_LEN, 5, number of presses per code word (>=1). Code bit 1 = button1 press, 0 = button0 press.
- GAP_CYCLES, 2, idle cycles (both buttons low) between consecutive presses (>=0).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to send; sampled only in IDLE
- code  input  CODE_LEN  code word, sent MSB first; captured on accepted start
- unlock  input  1  lock response; may be combinational from the button lines
- button0  output  1  press pulse for a 0 bit
- button1  output  1  press pulse for a 1 bit
- busy  output  1  high from the cycle after start acceptance until the DONE cycle inclusive
- done  output  1  one-cycle completion pulse
- success  output  1  result of the last send; held until the next accepted start

Behaviour:
- Reset (rst=1 at edge): state=IDLE, button0=button1=busy=done=success=0, index and gap counter cleared. Reset mid-send aborts immediately; no further presses occur.
- States:
  - IDLE: start=1 at edge -> capture code into shift register, index=CODE_LEN-1, success=0, go to PRESS.
  - PRESS (exactly 1 cycle): button1=code_reg[index], button0=~code_reg[index]. Exactly one button is high, never both.
    - If index==0: success<=unlock at this edge, go to DONE.
    - Else if GAP_CYCLES==0: index--, stay in PRESS.
    - Else: index--, load gap counter, go to GAP.
  - GAP: both buttons low. Count GAP_CYCLES cycles, then go to PRESS.
  - DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Latency:
  - Start accepted at edge k -> first press in cycle k+1.
  - Last press in cycle k+CODE_LEN+(CODE_LEN-1)*GAP_CYCLES.
  - done pulse in the following cycle.
- Button outputs are decoded only from registered state and the shift register, so they are glitch-free and have no combinational path from start or unlock.
- unlock is sampled only at the end of the final PRESS cycle. Values at all other times are ignored.
- start while busy (PRESS, GAP or DONE) is ignored. start in the DONE cycle is also ignored. Back-to-back sends require start in IDLE.
- A change of code during a send has no effect; the captured copy is used.
- Index and gap counters are sized $clog2 of their range, minimum 1 bit. The gap counter never wraps; it saturates at terminal count.

Decomposition:
- Shared package lock_pkg:
  - state encoding localparams: IDLE, PRESS, GAP, DONE (2-bit)
  - CODE_LEN default, shared with the lock so both ends agree on code width
- One natural sub-module: lock_gap_timer, a loadable down-counter with a terminal-count flag. The rest stays in a single FSM module.

Test Plan:
- Reset: assert rst for 2 cycles during GAP of a send -> buttons, busy, done and success all 0 on the next cycle; no presses until a new start.
- Code 5'b11010, GAP_CYCLES=2, loopback to a lock model accepting press sequence 1,1,0,1,0:
  - press sequence b1,b1,b0,b1,b0 at cycles k+1, k+4, k+7, k+10, k+13
  - done at k+14, success=1
- Code 5'b01011 to the same model -> all presses delivered, done pulses, success=0.
- GAP_CYCLES=0, code 5'b10101:
  - presses in 5 consecutive cycles with alternating buttons
  - done at k+6
  - button0 & button1 never high together
- start held high continuously:
  - second send begins only after return to IDLE, i.e. the first press of the second send is at done cycle + 2
  - start during PRESS, GAP and DONE is ignored
- Code input changed mid-send -> sequence matches the word captured at start; success held stable after done until the next start.
